// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: register file layout, register-pair accessors and the
// memory-bus sequencer's state and command types.
package gb_cpu_common_pkg;

    // Eight-bit register selectors; the value doubles as the index into regfile_t.
    typedef enum logic [3:0] {
        REG_A     = 4'd0,
        REG_F     = 4'd1,
        REG_B     = 4'd2,
        REG_C     = 4'd3,
        REG_D     = 4'd4,
        REG_E     = 4'd5,
        REG_H     = 4'd6,
        REG_L     = 4'd7,
        REG_SP_H  = 4'd8,
        REG_SP_L  = 4'd9,
        REG_PC_H  = 4'd10,
        REG_PC_L  = 4'd11,
        REG_TMP_H = 4'd12,
        REG_TMP_L = 4'd13,
        REG_IR    = 4'd14,
        REG_IE    = 4'd15
    } regfile_r8_t;

    // Sixteen-bit register pairs usable as an address source.
    typedef enum logic [2:0] {
        REG_AF  = 3'd0,
        REG_BC  = 3'd1,
        REG_DE  = 3'd2,
        REG_HL  = 3'd3,
        REG_SP  = 3'd4,
        REG_PC  = 3'd5,
        REG_TMP = 3'd6
    } regfile_r16_t;

    // Whole register file, one byte per regfile_r8_t entry.
    typedef logic [15:0][7:0] regfile_t;

    // Memory-bus sequencer states; T1..T4 are the four T-cycles of an M-cycle.
    typedef enum logic [2:0] {
        BUS_IDLE = 3'd0,
        BUS_T1   = 3'd1,
        BUS_T2   = 3'd2,
        BUS_T3   = 3'd3,
        BUS_T4   = 3'd4
    } bus_state_t;

    // One bus command as presented by the control unit.
    typedef struct packed {
        logic         write;
        regfile_r16_t addr_sel;
        logic         hi_page;
        regfile_r8_t  dst;
        logic [7:0]   wdata;
    } bus_cmd_t;

    localparam logic [7:0] BUS_HIGH_PAGE = 8'hFF;
    localparam logic [7:0] BUS_OPEN_DATA = 8'hFF;

    // High byte of a register pair.
    function automatic logic [7:0] getRegisterHigh(input regfile_t regs, input regfile_r16_t sel);
        case (sel)
            REG_AF:  return regs[REG_A];
            REG_BC:  return regs[REG_B];
            REG_DE:  return regs[REG_D];
            REG_HL:  return regs[REG_H];
            REG_SP:  return regs[REG_SP_H];
            REG_PC:  return regs[REG_PC_H];
            REG_TMP: return regs[REG_TMP_H];
            default: return 8'h00;
        endcase
    endfunction

    // Low byte of a register pair.
    function automatic logic [7:0] getRegisterLow(input regfile_t regs, input regfile_r16_t sel);
        case (sel)
            REG_AF:  return regs[REG_F];
            REG_BC:  return regs[REG_C];
            REG_DE:  return regs[REG_E];
            REG_HL:  return regs[REG_L];
            REG_SP:  return regs[REG_SP_L];
            REG_PC:  return regs[REG_PC_L];
            REG_TMP: return regs[REG_TMP_L];
            default: return 8'h00;
        endcase
    endfunction

    // Reads may only land in the instruction register or the temporaries.
    function automatic logic is_legal_read_dst(input regfile_r8_t dst);
        return (dst == REG_IR) || (dst == REG_TMP_L) || (dst == REG_TMP_H);
    endfunction

endpackage

// File: rtl/gb_cpu_bus_ctrl_if.sv
// Command, external memory bus and register-file write-back signals of the
// bus sequencer. Handshake: a command transfers on a clock edge where
// cmd_valid and cmd_ready are both high; cmd_valid may be held across
// cycles and is ignored while cmd_ready is low.
interface gb_cpu_bus_ctrl_if;
    import gb_cpu_common_pkg::*;

    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    regfile_r16_t cmd_addr_sel;
    logic         cmd_hi_page;
    regfile_r8_t  cmd_dst;
    logic [7:0]   cmd_wdata;

    logic [15:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata;
    logic         mem_ready;

    regfile_r8_t  data_bus_req;
    logic [7:0]   data_bus_data;
    logic         data_bus_wren;

    logic         done;
    logic         err;

    // Bus sequencer (initiator) view.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr_sel, cmd_hi_page, cmd_dst, cmd_wdata,
        output cmd_ready,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready,
        output data_bus_req, data_bus_data, data_bus_wren,
        output done, err
    );

    // Control unit / memory / register file view.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr_sel, cmd_hi_page, cmd_dst, cmd_wdata,
        input  cmd_ready,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready,
        input  data_bus_req, data_bus_data, data_bus_wren,
        input  done, err
    );

endinterface

// File: rtl/gb_cpu_bus_addr_sel.sv
// Register-pair to 16-bit address mux; LDH forms replace the high byte
// with the 0xFF page.
module gb_cpu_bus_addr_sel
    import gb_cpu_common_pkg::*;
(
    input  regfile_t     registers,
    input  regfile_r16_t addr_sel,
    input  logic         hi_page,
    output logic [15:0]  addr
);

    // High byte comes from the pair unless the high page is forced.
    always_comb begin
        addr = {getRegisterHigh(registers, addr_sel), getRegisterLow(registers, addr_sel)};
        if (hi_page) begin
            addr = {BUS_HIGH_PAGE, getRegisterLow(registers, addr_sel)};
        end
    end

endmodule

// File: rtl/gb_cpu_bus_ctrl.sv
// Game Boy CPU memory-bus sequencer: runs one 4-T-cycle read or write per
// accepted command and writes read data back into IR/TMP.
module gb_cpu_bus_ctrl
    import gb_cpu_common_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  regfile_t             registers,
    gb_cpu_bus_ctrl_if.master    bus,
    output bus_state_t           dbg_state
);

    localparam logic [3:0] WAIT_MAX = 4'(WAIT_LIMIT);

    bus_state_t  state;
    bus_state_t  next_state;
    bus_cmd_t    cmd_in;
    logic [15:0] cmd_addr;
    logic        write_q;
    regfile_r8_t dst_q;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        timeout;
    logic        completing;

    logic [15:0] mem_addr_d;
    logic [7:0]  mem_wdata_d;
    logic        mem_rd_d;
    logic        mem_wr_d;
    regfile_r8_t data_bus_req_d;
    logic [7:0]  data_bus_data_d;
    logic        data_bus_wren_d;
    logic        done_d;
    logic        err_d;
    logic        cmd_ready_d;

    assign dbg_state = state;

    // Gather the command fields into one record.
    always_comb begin
        cmd_in.write    = bus.cmd_write;
        cmd_in.addr_sel = bus.cmd_addr_sel;
        cmd_in.hi_page  = bus.cmd_hi_page;
        cmd_in.dst      = bus.cmd_dst;
        cmd_in.wdata    = bus.cmd_wdata;
    end

    gb_cpu_bus_addr_sel u_addr_sel (
        .registers (registers),
        .addr_sel  (cmd_in.addr_sel),
        .hi_page   (cmd_in.hi_page),
        .addr      (cmd_addr)
    );

    assign accept     = ((state == BUS_IDLE) || (state == BUS_T4)) && bus.cmd_valid;
    assign timeout    = (state == BUS_T3) && !bus.mem_ready && (wait_cnt == WAIT_MAX);
    assign completing = (state == BUS_T3) && (next_state == BUS_T4);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BUS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: fixed T1/T2, T3 stretched by wait states, T4 may chain into T1.
    always_comb begin
        next_state = state;
        case (state)
            BUS_IDLE: if (bus.cmd_valid) next_state = BUS_T1;
            BUS_T1:   next_state = BUS_T2;
            BUS_T2:   next_state = BUS_T3;
            BUS_T3:   if (bus.mem_ready || timeout) next_state = BUS_T4;
            BUS_T4:   next_state = bus.cmd_valid ? BUS_T1 : BUS_IDLE;
            default:  next_state = BUS_IDLE;
        endcase
    end

    // Latch the accepted command and count T3 wait cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q  <= 1'b0;
            dst_q    <= REG_IR;
            wait_cnt <= 4'd0;
        end else if (accept) begin
            write_q  <= cmd_in.write;
            dst_q    <= cmd_in.dst;
            wait_cnt <= 4'd0;
        end else if ((state == BUS_T3) && !bus.mem_ready && !timeout) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Output values for the coming cycle, derived from the transition being taken.
    always_comb begin
        mem_addr_d      = bus.mem_addr;
        mem_wdata_d     = bus.mem_wdata;
        mem_rd_d        = 1'b0;
        mem_wr_d        = 1'b0;
        data_bus_req_d  = bus.data_bus_req;
        data_bus_data_d = bus.data_bus_data;
        data_bus_wren_d = 1'b0;
        done_d          = 1'b0;
        err_d           = 1'b0;
        cmd_ready_d     = (next_state == BUS_IDLE) || (next_state == BUS_T4);

        if (accept) begin
            mem_addr_d = cmd_addr;
            if (cmd_in.write) begin
                mem_wdata_d = cmd_in.wdata;
            end
        end

        if ((next_state == BUS_T2) || (next_state == BUS_T3)) begin
            mem_rd_d = !write_q;
            mem_wr_d = write_q;
        end

        if (completing) begin
            done_d = 1'b1;
            err_d  = timeout || (!write_q && !is_legal_read_dst(dst_q));
            if (!write_q) begin
                data_bus_req_d  = dst_q;
                data_bus_data_d = bus.mem_ready ? bus.mem_rdata : BUS_OPEN_DATA;
                data_bus_wren_d = is_legal_read_dst(dst_q);
            end
        end
    end

    // Output registers; reset drops the strobes and write-back immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cmd_ready     <= 1'b1;
            bus.mem_addr      <= 16'h0000;
            bus.mem_wdata     <= 8'h00;
            bus.mem_rd        <= 1'b0;
            bus.mem_wr        <= 1'b0;
            bus.data_bus_req  <= REG_IR;
            bus.data_bus_data <= 8'h00;
            bus.data_bus_wren <= 1'b0;
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            bus.cmd_ready     <= cmd_ready_d;
            bus.mem_addr      <= mem_addr_d;
            bus.mem_wdata     <= mem_wdata_d;
            bus.mem_rd        <= mem_rd_d;
            bus.mem_wr        <= mem_wr_d;
            bus.data_bus_req  <= data_bus_req_d;
            bus.data_bus_data <= data_bus_data_d;
            bus.data_bus_wren <= data_bus_wren_d;
            bus.done          <= done_d;
            bus.err           <= err_d;
        end
    end

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Directed bench for gb_cpu_bus_ctrl: a table of single accesses plus
// hand-written back-to-back and mid-access reset sequences.
module tb_gb_cpu_bus_ctrl;
    import gb_cpu_common_pkg::*;

    logic       clk;
    logic       reset;
    regfile_t   regs;
    bus_state_t dbg_state;

    int tests_run;
    int tests_failed;

    gb_cpu_bus_ctrl_if bus ();

    gb_cpu_bus_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .registers (regs),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         write;
        regfile_r16_t sel;
        logic         hi;
        regfile_r8_t  dst;
        logic [7:0]   wdata;
        logic [7:0]   rdata;
        int           waits;
        logic [15:0]  exp_addr;
        logic [7:0]   exp_data;
        logic         exp_wren;
        logic         exp_err;
        int           exp_done;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'h0000);
        check({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'h00);
        check({tag, " strobes"}, {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
        check({tag, " data_bus_req"}, 32'(bus.data_bus_req), 32'(REG_IR));
        check({tag, " data_bus_data"}, 32'(bus.data_bus_data), 32'h00);
        check({tag, " wren_done_err"}, {29'd0, bus.data_bus_wren, bus.done, bus.err}, 32'd0);
        check({tag, " state"}, 32'(dbg_state), 32'(BUS_IDLE));
    endtask

    task automatic drive_cmd(input logic write, input regfile_r16_t sel, input logic hi,
                             input regfile_r8_t dst, input logic [7:0] wdata);
        bus.cmd_write    = write;
        bus.cmd_addr_sel = sel;
        bus.cmd_hi_page  = hi;
        bus.cmd_dst      = dst;
        bus.cmd_wdata    = wdata;
    endtask

    // One access from idle; mem_ready is released after v.waits T3 cycles.
    task automatic run_vec(input int idx, input vec_t v);
        logic seen_done;
        logic excl_ok;
        logic early_wren;
        string p;
        p = $sformatf("vec%0d", idx);
        @(negedge clk);
        check({p, " idle_ready"}, 32'(bus.cmd_ready), 32'd1);
        drive_cmd(v.write, v.sel, v.hi, v.dst, v.wdata);
        bus.cmd_valid = 1'b1;
        bus.mem_rdata = v.rdata;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        seen_done  = 1'b0;
        excl_ok    = 1'b1;
        early_wren = 1'b0;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            @(negedge clk);
            if (bus.mem_rd && bus.mem_wr) excl_ok = 1'b0;
            if (c == 1) begin
                check({p, " t1_addr"}, 32'(bus.mem_addr), 32'(v.exp_addr));
                check({p, " t1_strobes"}, {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
                if (v.write) check({p, " t1_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
            end
            if (c == 2) begin
                check({p, " t2_rd"}, 32'(bus.mem_rd), 32'(!v.write));
                check({p, " t2_wr"}, 32'(bus.mem_wr), 32'(v.write));
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check({p, " done_cycle"}, 32'(c), 32'(v.exp_done));
                check({p, " wren"}, 32'(bus.data_bus_wren), 32'(v.exp_wren));
                check({p, " err"}, 32'(bus.err), 32'(v.exp_err));
                check({p, " t4_addr"}, 32'(bus.mem_addr), 32'(v.exp_addr));
                check({p, " t4_strobes"}, {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
                if (v.exp_wren) begin
                    check({p, " data"}, 32'(bus.data_bus_data), 32'(v.exp_data));
                    check({p, " req"}, 32'(bus.data_bus_req), 32'(v.dst));
                end
            end else if (bus.data_bus_wren) begin
                early_wren = 1'b1;
            end
            bus.mem_ready = (c >= 3 + v.waits) ? 1'b1 : 1'b0;
        end
        check({p, " done_seen"}, 32'(seen_done), 32'd1);
        check({p, " strobe_excl"}, 32'(excl_ok), 32'd1);
        check({p, " no_early_wren"}, 32'(early_wren), 32'd0);
        @(negedge clk);
        check({p, " pulse_end"}, {29'd0, bus.data_bus_wren, bus.done, bus.err}, 32'd0);
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        int wren_cnt;
        int bad_pulse;
        tests_run    = 0;
        tests_failed = 0;

        regs = '0;
        regs[REG_A]     = 8'h01;  regs[REG_F]     = 8'hB0;
        regs[REG_B]     = 8'h12;  regs[REG_C]     = 8'h44;
        regs[REG_D]     = 8'h80;  regs[REG_E]     = 8'h01;
        regs[REG_H]     = 8'hC0;  regs[REG_L]     = 8'hDE;
        regs[REG_SP_H]  = 8'hFF;  regs[REG_SP_L]  = 8'hFE;
        regs[REG_PC_H]  = 8'h01;  regs[REG_PC_L]  = 8'h50;
        regs[REG_TMP_H] = 8'hAB;  regs[REG_TMP_L] = 8'hCD;

        //          wr    sel     hi    dst        wdata  rdata  waits addr      data   wren  err   done
        vecs[0] = '{1'b0, REG_PC,  1'b0, REG_IR,    8'h00, 8'h3E, 0,  16'h0150, 8'h3E, 1'b1, 1'b0, 4};
        vecs[1] = '{1'b1, REG_BC,  1'b1, REG_IR,    8'h80, 8'h00, 0,  16'hFF44, 8'h00, 1'b0, 1'b0, 4};
        vecs[2] = '{1'b0, REG_HL,  1'b1, REG_TMP_L, 8'h00, 8'h77, 0,  16'hFFDE, 8'h77, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b1, REG_DE,  1'b0, REG_IR,    8'h5A, 8'hEE, 0,  16'h8001, 8'h00, 1'b0, 1'b0, 4};
        vecs[4] = '{1'b0, REG_PC,  1'b0, REG_IR,    8'h00, 8'h5A, 3,  16'h0150, 8'h5A, 1'b1, 1'b0, 7};
        vecs[5] = '{1'b0, REG_SP,  1'b0, REG_TMP_H, 8'h00, 8'hC3, 15, 16'hFFFE, 8'hC3, 1'b1, 1'b0, 19};
        vecs[6] = '{1'b0, REG_HL,  1'b0, REG_IR,    8'h00, 8'h11, 99, 16'hC0DE, 8'hFF, 1'b1, 1'b1, 19};
        vecs[7] = '{1'b0, REG_TMP, 1'b0, REG_A,     8'h00, 8'h22, 0,  16'hABCD, 8'h00, 1'b0, 1'b1, 4};
        vecs[8] = '{1'b1, REG_AF,  1'b0, REG_IR,    8'h9C, 8'h00, 99, 16'h01B0, 8'h00, 1'b0, 1'b1, 19};

        bus.cmd_valid = 1'b0;
        drive_cmd(1'b0, REG_PC, 1'b0, REG_IR, 8'h00);
        bus.mem_rdata = 8'h00;
        bus.mem_ready = 1'b0;

        // Reset values, during and just after reset.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back reads: second command accepted in T4 of the first.
        @(negedge clk);
        drive_cmd(1'b0, REG_PC, 1'b0, REG_TMP_L, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'hA1;
        @(posedge clk);
        #1;
        drive_cmd(1'b0, REG_HL, 1'b0, REG_TMP_H, 8'h00);
        wren_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.data_bus_wren) wren_cnt++;
            if (c == 4) begin
                check("b2b c4 wren", 32'(bus.data_bus_wren), 32'd1);
                check("b2b c4 req", 32'(bus.data_bus_req), 32'(REG_TMP_L));
                check("b2b c4 data", 32'(bus.data_bus_data), 32'hA1);
                check("b2b c4 ready", 32'(bus.cmd_ready), 32'd1);
                bus.mem_rdata = 8'hB2;
            end
            if (c == 5) begin
                check("b2b c5 state", 32'(dbg_state), 32'(BUS_T1));
                check("b2b c5 addr", 32'(bus.mem_addr), 32'hC0DE);
                bus.cmd_valid = 1'b0;
            end
            if (c == 8) begin
                check("b2b c8 wren", 32'(bus.data_bus_wren), 32'd1);
                check("b2b c8 req", 32'(bus.data_bus_req), 32'(REG_TMP_H));
                check("b2b c8 data", 32'(bus.data_bus_data), 32'hB2);
            end
            if (c == 9) check("b2b c9 state", 32'(dbg_state), 32'(BUS_IDLE));
        end
        check("b2b wren_count", 32'(wren_cnt), 32'd2);
        bus.mem_ready = 1'b0;

        // Reset pulled low during T2 of a read.
        @(negedge clk);
        drive_cmd(1'b0, REG_PC, 1'b0, REG_IR, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'h99;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid t2_rd", 32'(bus.mem_rd), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid rd_async", 32'(bus.mem_rd), 32'd0);
        bad_pulse = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.data_bus_wren || bus.done) bad_pulse++;
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.data_bus_wren || bus.done) bad_pulse++;
        end
        check("rst_mid no_pulse", 32'(bad_pulse), 32'd0);
        check_reset_values("rst_mid after");
        bus.mem_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1);
    end

endmodule
